// File: rtl/pipe_test_pkg.sv
// Shared definitions for the block-throttled pipe source and its checker:
// pattern codes, LFSR seed/taps and the source FSM state type.
package pipe_test_pkg;

  localparam logic [2:0]  PAT_LFSR  = 3'd0;
  localparam logic [2:0]  PAT_COUNT = 3'd1;
  localparam logic [2:0]  PAT_WALK1 = 3'd2;
  localparam logic [2:0]  PAT_FIXED = 3'd3;

  localparam logic [31:0] LFSR_SEED = 32'h0000_0001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_RDY,
    ST_STROBE,
    ST_BURST,
    ST_DONE
  } pipe_state_e;

  function automatic logic [31:0] lfsr_next(input logic [31:0] x);
    return {x[30:0], x[31] ^ x[21] ^ x[1] ^ x[0]};
  endfunction

endpackage

// File: rtl/pipe_pattern_gen.sv
// Pattern word generator: seeded on load, steps only when a word is consumed.
module pipe_pattern_gen
  import pipe_test_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic        advance,
  input  logic [2:0]  pattern,
  input  logic [31:0] fixed_pattern,
  output logic [31:0] word
);

  logic [2:0]  r_pat;
  logic [31:0] r_word;
  logic [31:0] w_seed;
  logic [31:0] w_next;

  always_comb begin
    case (pattern)
      PAT_COUNT: w_seed = 32'd0;
      PAT_WALK1: w_seed = 32'd1;
      PAT_FIXED: w_seed = fixed_pattern;
      default:   w_seed = LFSR_SEED;
    endcase
  end

  // Fixed pattern simply holds the word it was seeded with.
  always_comb begin
    case (r_pat)
      PAT_COUNT: w_next = r_word + 32'd1;
      PAT_WALK1: w_next = {r_word[30:0], r_word[31]};
      PAT_FIXED: w_next = r_word;
      default:   w_next = lfsr_next(r_word);
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pat  <= PAT_LFSR;
      r_word <= LFSR_SEED;
    end else if (load) begin
      r_pat  <= pattern;
      r_word <= w_seed;
    end else if (advance) begin
      r_word <= w_next;
    end
  end

  assign word = r_word;

endmodule

// File: rtl/bt_pipe_block_source.sv
// Block-throttled PipeIn source: strobe, then one block of pattern words,
// repeated for the programmed number of blocks.
//
// state       | meaning
// ST_IDLE     | no run; accepts start
// ST_WAIT_RDY | waiting for ep_ready before the next block
// ST_STROBE   | ep_blockstrobe high this cycle
// ST_BURST    | writing the block, gated by throttle bit0
// ST_DONE     | finishing the run; done pulses, then busy drops
module bt_pipe_block_source
  import pipe_test_pkg::*;
#(
  parameter int unsigned BLOCK_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] num_blocks,
  input  logic [2:0]  pattern,
  input  logic [31:0] fixed_pattern,
  input  logic        throttle_set,
  input  logic [31:0] throttle_val,
  input  logic        ep_ready,
  output logic        ep_blockstrobe,
  output logic        ep_write,
  output logic [31:0] ep_dataout,
  output logic        busy,
  output logic        done,
  output logic [31:0] words_sent
);

  localparam logic [15:0] WORDS = 16'(BLOCK_WORDS);

  pipe_state_e r_state, w_state;
  logic [15:0] r_blocks_left, w_blocks_left;
  logic [15:0] r_word_idx, w_word_idx;
  logic [31:0] r_throttle, w_throttle;
  logic        r_strobe, w_strobe;
  logic        r_write, w_write;
  logic [31:0] r_data, w_data;
  logic        r_busy, w_busy;
  logic        r_done, w_done;
  logic [31:0] r_words_sent, w_words_sent;
  logic        w_load;
  logic        w_advance;
  logic        w_emit;
  logic [31:0] w_gen_word;

  pipe_pattern_gen u_gen (
    .clk           (clk),
    .reset_n       (reset_n),
    .load          (w_load),
    .advance       (w_advance),
    .pattern       (pattern),
    .fixed_pattern (fixed_pattern),
    .word          (w_gen_word)
  );

  // Writes are registered one edge ahead, so the decision uses the throttle
  // value that will be current in the cycle the word is presented.
  always_comb begin
    w_state       = r_state;
    w_blocks_left = r_blocks_left;
    w_word_idx    = r_word_idx;
    w_throttle    = throttle_set ? throttle_val : {r_throttle[0], r_throttle[31:1]};
    w_strobe      = 1'b0;
    w_write       = 1'b0;
    w_data        = r_data;
    w_busy        = r_busy;
    w_done        = 1'b0;
    w_words_sent  = r_words_sent;
    w_load        = 1'b0;
    w_advance     = 1'b0;
    w_emit        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_load        = 1'b1;
          w_busy        = 1'b1;
          w_words_sent  = 32'd0;
          w_blocks_left = num_blocks;
          w_state       = (num_blocks == 16'd0) ? ST_DONE : ST_WAIT_RDY;
        end
      end
      ST_WAIT_RDY: begin
        if (ep_ready) begin
          w_strobe   = 1'b1;
          w_word_idx = 16'd0;
          w_state    = ST_STROBE;
        end
      end
      ST_STROBE: begin
        w_emit  = w_throttle[0];
        w_state = ST_BURST;
      end
      ST_BURST: begin
        if (r_word_idx == WORDS) begin
          w_blocks_left = r_blocks_left - 16'd1;
          if (r_blocks_left == 16'd1) begin
            w_done  = 1'b1;
            w_state = ST_DONE;
          end else begin
            w_state = ST_WAIT_RDY;
          end
        end else begin
          w_emit = w_throttle[0];
        end
      end
      ST_DONE: begin
        // Entered without a done pulse on an empty run; raise it here first.
        if (r_done) begin
          w_busy  = 1'b0;
          w_state = ST_IDLE;
        end else begin
          w_done = 1'b1;
        end
      end
      default: w_state = ST_IDLE;
    endcase

    if (w_emit) begin
      w_write      = 1'b1;
      w_data       = w_gen_word;
      w_advance    = 1'b1;
      w_words_sent = r_words_sent + 32'd1;
      w_word_idx   = r_word_idx + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_blocks_left <= 16'd0;
      r_word_idx    <= 16'd0;
      r_throttle    <= 32'hFFFF_FFFF;
      r_strobe      <= 1'b0;
      r_write       <= 1'b0;
      r_data        <= 32'd0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_words_sent  <= 32'd0;
    end else begin
      r_state       <= w_state;
      r_blocks_left <= w_blocks_left;
      r_word_idx    <= w_word_idx;
      r_throttle    <= w_throttle;
      r_strobe      <= w_strobe;
      r_write       <= w_write;
      r_data        <= w_data;
      r_busy        <= w_busy;
      r_done        <= w_done;
      r_words_sent  <= w_words_sent;
    end
  end

  assign ep_blockstrobe = r_strobe;
  assign ep_write       = r_write;
  assign ep_dataout     = r_data;
  assign busy           = r_busy;
  assign done           = r_done;
  assign words_sent     = r_words_sent;

endmodule
